bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: IDLE -> GRANT -> TURN, owner releases by dropping its req.
// Define BUS_ARB_TIMEOUT_EN to build in the bus_ready watchdog with sticky error and requester masking.
module bus_arbiter_rr #(
  parameter int NREQ    = 8,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            bus_req,
  input  logic            bus_ready,
  output logic [IDW-1:0]  owner,
  output logic            busy,
  output logic            timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [IDW-1:0]  owner_reg, owner_next;
  logic [IDW-1:0]  last_owner_reg, last_owner_next;
  logic [NREQ-1:0] eligible;
  logic            pick_valid;
  logic [IDW-1:0]  pick_idx;
  logic            owner_req;
  logic            expire;
  int              cand;

  assign owner_req = req[owner_reg];
  assign busy      = (state_reg == GRANT);
  assign bus_req   = busy & owner_req;
  assign grant     = grant_reg;
  assign owner     = owner_reg;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT) + 1;

  logic [WDW-1:0]  wd_cnt_reg;
  logic            err_reg;
  logic [NREQ-1:0] mask_reg, mask_next;

  // Expires on the edge where the count would reach TIMEOUT, so grant lasts TIMEOUT cycles.
  assign expire      = busy && owner_req && !bus_ready && (wd_cnt_reg == WDW'(TIMEOUT - 1));
  assign timeout_err = err_reg;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_req
    assign eligible[gi]  = req[gi] & ~mask_reg[gi];
    // A timed-out requester stays masked until its req is seen low.
    assign mask_next[gi] = (expire && (owner_reg == IDW'(gi))) ? 1'b1 : (mask_reg[gi] & req[gi]);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
      mask_reg   <= '0;
    end else begin
      if (state_reg == GRANT) begin
        if (bus_ready)
          wd_cnt_reg <= '0;
        else if (wd_cnt_reg != WDW'(TIMEOUT))
          wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end else begin
        wd_cnt_reg <= '0;
      end
      if (expire)
        err_reg <= 1'b1;
      mask_reg <= mask_next;
    end
  end
`else
  assign expire = 1'b0;
  // TIMEOUT has no effect in this build; the comparison folds to constant 0.
  assign timeout_err = (TIMEOUT < 0);

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_req
    assign eligible[gi] = req[gi];
  end
`endif

  // First eligible requester searching upward from last_owner+1 with wrap-around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(last_owner_reg) + i) % NREQ;
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next      = GRANT;
          grant_next      = NREQ'(1) << pick_idx;
          owner_next      = pick_idx;
          last_owner_next = pick_idx;
        end
      end
      GRANT: begin
        if (!owner_req || expire) begin
          state_next = TURN;
          grant_next = '0;
        end
      end
      TURN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IDW'(NREQ - 1);
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomized and directed bench for bus_arbiter_rr against a rotation-based reference model.
// Expectations follow BUS_ARB_TIMEOUT_EN the same way the design does.
module tb_bus_arbiter_rr;

  localparam int NREQ    = 8;
  localparam int IDW     = 3;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            clr;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            bus_req;
  logic            bus_ready;
  logic [IDW-1:0]  owner;
  logic            busy;
  logic            timeout_err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: who holds the bus, turnaround edges to skip, rotation pointer.
  int              m_holder;
  int              m_skip;
  int              m_last;
  int              m_owner;
  int              m_age;
  logic            m_err;
  logic [NREQ-1:0] m_blocked;

  bus_arbiter_rr #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .clr         (clr),
    .req         (req),
    .grant       (grant),
    .bus_req     (bus_req),
    .bus_ready   (bus_ready),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last, input logic [NREQ-1:0] blk);
    for (int k = 1; k <= NREQ; k++) begin
      int c = (last + k) % NREQ;
      if (r[c] && !blk[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_grant();
    logic [NREQ-1:0] g = '0;
    if (m_holder >= 0) g[m_holder] = 1'b1;
    return g;
  endfunction

  function automatic logic exp_bus_req(input logic [NREQ-1:0] r);
    if (m_holder < 0) return 1'b0;
    return r[m_holder];
  endfunction

  task automatic model_reset();
    m_holder  = -1;
    m_skip    = 0;
    m_last    = NREQ - 1;
    m_owner   = 0;
    m_age     = 0;
    m_err     = 1'b0;
    m_blocked = '0;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] r, input logic rdy);
    int c;
    if (m_holder >= 0) begin
      if (!r[m_holder]) begin
        m_holder = -1;
        m_skip   = 1;
      end else begin
        if (rdy) m_age = 0;
        else     m_age = m_age + 1;
`ifdef BUS_ARB_TIMEOUT_EN
        if (m_age == TIMEOUT) begin
          m_blocked[m_holder] = 1'b1;
          m_err    = 1'b1;
          m_holder = -1;
          m_skip   = 1;
        end
`endif
      end
    end else if (m_skip > 0) begin
      m_skip = m_skip - 1;
    end else begin
      c = rr_pick(r, m_last, m_blocked);
      if (c >= 0) begin
        m_holder = c;
        m_owner  = c;
        m_last   = c;
        m_age    = 0;
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (!r[i]) m_blocked[i] = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("grant", grant, exp_grant());
    check_eq("owner", owner, m_owner);
    check_eq("busy", busy, m_holder >= 0);
    check_eq("bus_req", bus_req, exp_bus_req(req));
    check_eq("timeout_err", timeout_err, m_err);
  endtask

  // Called with clk low: drive inputs, clock once, then check after the falling edge.
  task automatic cycle(input logic [NREQ-1:0] r, input logic rdy);
    req       = r;
    bus_ready = rdy;
    #1 check_eq("bus_req_comb", bus_req, exp_bus_req(r));
    @(posedge clk);
    model_edge(r, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr       = 1'b0;
    req       = '0;
    bus_ready = 1'b1;
    model_reset();
    #1 check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    clr = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [NREQ-1:0] r;
    logic            rdy;
    int              n;
    int              guard;

    clr       = 1'b0;
    req       = 8'h05;
    bus_ready = 1'b1;
    model_reset();

    // Reset release with requesters 0 and 2 pending: 0 wins first.
    do_reset();
    cycle(8'h05, 1'b1);
    check_eq("first_grant", grant, 8'h01);
    check_eq("first_owner", owner, 0);
    check_eq("first_bus_req", bus_req, 1'b1);

    // Release by requester 0: TURN, IDLE, then requester 2.
    cycle(8'h04, 1'b1);
    check_eq("turn_grant", grant, 8'h00);
    cycle(8'h04, 1'b1);
    check_eq("idle_grant", grant, 8'h00);
    cycle(8'h04, 1'b1);
    check_eq("rel_grant", grant, 8'h04);
    check_eq("rel_owner", owner, 2);
    cycle(8'h00, 1'b1);

    // Pulse wholly between edges is never seen.
    repeat (2) cycle(8'h00, 1'b1);
    #1 req = 8'h40;
    #2 req = 8'h00;
    cycle(8'h00, 1'b1);
    check_eq("pulse_ignored", grant, 8'h00);

    // Fairness with every requester asking: 0..7 then 0.
    do_reset();
    n     = 0;
    guard = 0;
    while (n < NREQ + 1 && guard < 200) begin
      guard++;
      cycle('1, 1'b1);
      if (m_holder >= 0) begin
        check_eq("fair_owner", owner, n % NREQ);
        n++;
        cycle('1, 1'b1);
        r = '1;
        r[m_holder] = 1'b0;
        cycle(r, 1'b1);
      end
    end
    check_eq("fair_count", n, NREQ + 1);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    cycle(8'h02, 1'b1);
    check_eq("pre_rst_grant", grant, 8'h02);
    #2 clr = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_grant", grant, 8'h00);
    check_eq("mid_rst_bus_req", bus_req, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    cycle(8'h02, 1'b1);
    check_eq("post_rst_grant", grant, 8'h02);
    cycle(8'h00, 1'b1);

    // Requester 3 holds the bus with no bus_ready; requester 4 waits.
    do_reset();
    cycle(8'h08, 1'b0);
    check_eq("wd_start", grant, 8'h08);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cycle(8'h18, 1'b0);
`ifndef BUS_ARB_TIMEOUT_EN
      check_eq("nowd_grant", grant, 8'h08);
      check_eq("nowd_err", timeout_err, 1'b0);
`endif
    end
`ifdef BUS_ARB_TIMEOUT_EN
    check_eq("wd_grant_drop", grant, 8'h00);
    check_eq("wd_err", timeout_err, 1'b1);
    cycle(8'h18, 1'b0);
    cycle(8'h18, 1'b0);
    check_eq("wd_next_grant", grant, 8'h10);
    cycle(8'h08, 1'b1);
    repeat (4) cycle(8'h08, 1'b1);
    check_eq("wd_masked", grant, 8'h00);
    check_eq("wd_err_sticky", timeout_err, 1'b1);
    cycle(8'h00, 1'b1);
    cycle(8'h08, 1'b1);
    check_eq("wd_regrant", grant, 8'h08);
`else
    repeat (6) cycle(8'h18, 1'b1);
    check_eq("nowd_persist", grant, 8'h08);
    check_eq("nowd_err_end", timeout_err, 1'b0);
`endif

    // Random traffic with stalled-slave phases and one reset midway.
    do_reset();
    r = '0;
    for (int t = 0; t < 600; t++) begin
      if (t == 300) begin
        do_reset();
        r = '0;
      end
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      if ((t / 40) % 3 == 2) rdy = 1'b0;
      else                   rdy = ($urandom_range(0, 3) != 0);
      cycle(r, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
